// File: rtl/rm_violation_reporter_pkg.sv
// Shared types and constants for the runtime-monitor violation reporting path.
// Lane/rule counts are shared with the monitor and event router.
package rm_violation_reporter_pkg;

   localparam int unsigned NUM_RM_LANES  = 4;
   localparam int unsigned NUM_RM_RULES  = 5;
   localparam int unsigned RM_FIFO_DEPTH = 4;
   localparam int unsigned VLEN          = 64;
   localparam int unsigned RM_LANE_W     = $clog2(NUM_RM_LANES);

   typedef struct packed {
      logic [RM_LANE_W-1:0]    lane;
      logic [NUM_RM_RULES-1:0] rules;
      logic [VLEN-1:0]         pc;
   } rm_report_t;

   // One-hot lane mask from a lane index
   function automatic logic [NUM_RM_LANES-1:0] lane_onehot(input logic [RM_LANE_W-1:0] lane);
      return NUM_RM_LANES'(1) << lane;
   endfunction

endpackage

// File: rtl/rm_violation_reporter_fifo.sv
// Generic show-ahead FIFO with registered storage; head entry is always visible on data_o.
// Flush wins over push/pop; push into a full FIFO is accepted only alongside a pop.
module rm_report_fifo #(
   parameter type         entry_t = logic,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  entry_t                 data_i,
   input  logic                   pop_i,
   output entry_t                 data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   always_comb begin
      mem_d = mem_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = wr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
         end
         cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rm_violation_reporter.sv
// Turns rising rule flags per monitor lane into violation reports, queues them and
// hands them to the core over valid/ready; pulses a per-lane release on each accepted report.
module rm_violation_reporter
   import rm_violation_reporter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = RM_FIFO_DEPTH
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 flush_i,
   input  logic [NUM_RM_LANES*NUM_RM_RULES-1:0] monitor_i,
   input  logic [NUM_RM_LANES-1:0]              lane_reset_i,
   input  logic [NUM_RM_LANES*VLEN-1:0]         lane_pc_i,
   output logic                                 report_valid_o,
   input  logic                                 report_ready_i,
   output logic [RM_LANE_W-1:0]                 report_lane_o,
   output logic [NUM_RM_RULES-1:0]              report_rules_o,
   output logic [VLEN-1:0]                      report_pc_o,
   output logic [NUM_RM_LANES-1:0]              lane_release_o,
   output logic [$clog2(FIFO_DEPTH):0]          fifo_count_o,
   output logic [7:0]                           merge_cnt_o
);

   localparam int unsigned NL = NUM_RM_LANES;
   localparam int unsigned NR = NUM_RM_RULES;

   typedef logic [NL-1:0][NR-1:0] rule_vec_t;

   rule_vec_t               mon_in, new_hits;
   rule_vec_t               mon_q, mon_d, pend_q, pend_d;
   logic [NL-1:0][VLEN-1:0] lane_pc, pc_q, pc_d;
   logic [RM_LANE_W-1:0]    rr_q, rr_d, grant_lane;
   logic [NL-1:0]           eligible, release_q, release_d;
   logic [7:0]              merge_cnt_q, merge_cnt_d;
   logic [RM_LANE_W:0]      merge_hits;
   logic [8:0]              merge_sum;
   logic                    grant_found, push, pop, fifo_full, fifo_empty;
   rm_report_t              push_entry, head;

   assign mon_in   = monitor_i;
   assign lane_pc  = lane_pc_i;
   assign new_hits = mon_in & ~mon_q;

   // Round-robin grant over lanes with pending hits, skipping lanes being reset
   always_comb begin
      eligible    = '0;
      grant_found = 1'b0;
      grant_lane  = rr_q;
      for (int unsigned l = 0; l < NL; l++) begin
         eligible[l] = (|pend_q[l]) & ~lane_reset_i[l];
      end
      for (int unsigned i = 0; i < NL; i++) begin
         if (!grant_found && eligible[RM_LANE_W'((32'(rr_q) + i) % NL)]) begin
            grant_found = 1'b1;
            grant_lane  = RM_LANE_W'((32'(rr_q) + i) % NL);
         end
      end
   end

   assign pop  = report_valid_o & report_ready_i & ~flush_i;
   assign push = grant_found & (~fifo_full | pop) & ~flush_i;

   always_comb begin
      push_entry       = '0;
      push_entry.lane  = grant_lane;
      push_entry.rules = pend_q[grant_lane];
      push_entry.pc    = pc_q[grant_lane];
   end

   // Edge detect, pending accumulation, PC capture and merge accounting
   always_comb begin
      mon_d      = mon_in;
      pend_d     = pend_q;
      pc_d       = pc_q;
      rr_d       = rr_q;
      merge_hits = '0;
      release_d  = pop ? lane_onehot(head.lane) : '0;
      if (push) begin
         rr_d = RM_LANE_W'((32'(grant_lane) + 1) % NL);
      end
      for (int unsigned l = 0; l < NL; l++) begin
         if (flush_i || lane_reset_i[l]) begin
            mon_d[l]  = '0;
            pend_d[l] = '0;
         end else if (push && grant_lane == RM_LANE_W'(l)) begin
            // Hits landing on the cycle the lane drains start a fresh report
            pend_d[l] = new_hits[l];
            if (|new_hits[l]) begin
               pc_d[l] = lane_pc[l];
            end
         end else begin
            pend_d[l] = pend_q[l] | new_hits[l];
            if (|new_hits[l]) begin
               if (|pend_q[l]) begin
                  merge_hits = merge_hits + (RM_LANE_W+1)'(1);
               end else begin
                  pc_d[l] = lane_pc[l];
               end
            end
         end
      end
      merge_sum   = 9'(merge_cnt_q) + 9'(merge_hits);
      merge_cnt_d = merge_sum[8] ? 8'hFF : merge_sum[7:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mon_q       <= '0;
         pend_q      <= '0;
         pc_q        <= '0;
         rr_q        <= '0;
         merge_cnt_q <= '0;
         release_q   <= '0;
      end else begin
         mon_q       <= mon_d;
         pend_q      <= pend_d;
         pc_q        <= pc_d;
         rr_q        <= rr_d;
         merge_cnt_q <= merge_cnt_d;
         release_q   <= release_d;
      end
   end

   rm_report_fifo #(
      .entry_t (rm_report_t),
      .DEPTH   (FIFO_DEPTH)
   ) i_report_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count_o)
   );

   assign report_valid_o = ~fifo_empty;
   assign report_lane_o  = head.lane;
   assign report_rules_o = head.rules;
   assign report_pc_o    = head.pc;
   assign lane_release_o = release_q;
   assign merge_cnt_o    = merge_cnt_q;

endmodule
